// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences IF/ID/EXE/MEM/WB and drives datapath enables/selects.
// Optional build macro MCTRL_HALT_EN: halt parks the FSM in sIF until Reset; otherwise halt is an illegal-opcode nop.
module multicycle_ctrl (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       ExtSel,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic [2:0] state
);
    // state   | meaning
    // S_IF    | fetch, load IR
    // S_ID    | decode; jumps and nops retire here
    // S_EXE_AL| ALU operation
    // S_EXE_BR| beq compare and PC update
    // S_EXE_LS| load/store address calculation
    // S_MEM   | data memory access
    // S_WB_AL | ALU result write-back
    // S_WB_LD | load data write-back
    localparam logic [2:0] S_IF     = 3'b000;
    localparam logic [2:0] S_ID     = 3'b001;
    localparam logic [2:0] S_EXE_AL = 3'b110;
    localparam logic [2:0] S_EXE_BR = 3'b101;
    localparam logic [2:0] S_EXE_LS = 3'b010;
    localparam logic [2:0] S_MEM    = 3'b011;
    localparam logic [2:0] S_WB_AL  = 3'b111;
    localparam logic [2:0] S_WB_LD  = 3'b100;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
`ifdef MCTRL_HALT_EN
    localparam logic [5:0] OP_HALT = 6'b111111;
`endif

    logic [2:0] state_q, state_d;
    logic       halted_q;

    logic       is_alu, is_imm, is_sext, is_sll, is_beq, is_lw, is_sw;
    logic       is_j, is_jr, is_jal, is_halt;
    logic [2:0] alu_op_dec;

    always_comb begin
        is_alu     = 1'b0;
        is_imm     = 1'b0;
        is_sext    = 1'b0;
        is_sll     = 1'b0;
        is_beq     = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_j       = 1'b0;
        is_jr      = 1'b0;
        is_jal     = 1'b0;
        is_halt    = 1'b0;
        alu_op_dec = 3'b000;
        case (opcode)
            OP_ADD:  is_alu = 1'b1;
            OP_SUB:  begin is_alu = 1'b1; alu_op_dec = 3'b001; end
            OP_ADDI: begin is_alu = 1'b1; is_imm = 1'b1; is_sext = 1'b1; end
            OP_OR:   begin is_alu = 1'b1; alu_op_dec = 3'b010; end
            OP_AND:  begin is_alu = 1'b1; alu_op_dec = 3'b011; end
            OP_ORI:  begin is_alu = 1'b1; is_imm = 1'b1; alu_op_dec = 3'b010; end
            OP_SLL:  begin is_alu = 1'b1; is_sll = 1'b1; alu_op_dec = 3'b100; end
            OP_SLT:  begin is_alu = 1'b1; alu_op_dec = 3'b101; end
            OP_SW:   is_sw   = 1'b1;
            OP_LW:   is_lw   = 1'b1;
            OP_BEQ:  is_beq  = 1'b1;
            OP_J:    is_j    = 1'b1;
            OP_JR:   is_jr   = 1'b1;
            OP_JAL:  is_jal  = 1'b1;
`ifdef MCTRL_HALT_EN
            OP_HALT: is_halt = 1'b1;
`endif
            default: ;
        endcase
    end

`ifdef MCTRL_HALT_EN
    logic halted_d;

    always_comb begin
        halted_d = halted_q;
        if (state_q == S_ID && is_halt) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    assign halted_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:     state_d = halted_q ? S_IF : S_ID;
            S_ID: begin
                if (is_alu)             state_d = S_EXE_AL;
                else if (is_beq)        state_d = S_EXE_BR;
                else if (is_lw || is_sw) state_d = S_EXE_LS;
                else                    state_d = S_IF;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    logic       pc_wre_r, ir_wre_r, ext_sel_r, alu_src_a_r, alu_src_b_r;
    logic       reg_wre_r, wr_src_r, db_src_r, mrd_r, mwr_r;
    logic [1:0] pc_src_r, reg_dst_r;
    logic [2:0] alu_op_r;

    always_comb begin
        pc_wre_r    = 1'b0;
        pc_src_r    = 2'b00;
        ir_wre_r    = 1'b0;
        ext_sel_r   = 1'b0;
        alu_src_a_r = 1'b0;
        alu_src_b_r = 1'b0;
        alu_op_r    = 3'b000;
        reg_wre_r   = 1'b0;
        reg_dst_r   = 2'b00;
        wr_src_r    = 1'b0;
        db_src_r    = 1'b0;
        mrd_r       = 1'b0;
        mwr_r       = 1'b0;
        case (state_q)
            S_IF: ir_wre_r = !halted_q;
            S_ID: begin
                if (is_j) begin
                    pc_wre_r = 1'b1;
                    pc_src_r = 2'b10;
                end else if (is_jr) begin
                    pc_wre_r = 1'b1;
                    pc_src_r = 2'b11;
                end else if (is_jal) begin
                    pc_wre_r  = 1'b1;
                    pc_src_r  = 2'b10;
                    reg_wre_r = 1'b1;
                end else if (!(is_alu || is_beq || is_lw || is_sw || is_halt)) begin
                    pc_wre_r = 1'b1;
                end
            end
            S_EXE_AL, S_WB_AL: begin
                // ALU selects stay valid through write-back so the result bus is stable
                alu_op_r    = alu_op_dec;
                alu_src_a_r = is_sll;
                alu_src_b_r = is_imm;
                ext_sel_r   = is_sext;
                if (state_q == S_WB_AL) begin
                    reg_wre_r = 1'b1;
                    wr_src_r  = 1'b1;
                    pc_wre_r  = 1'b1;
                    reg_dst_r = is_imm ? 2'b01 : 2'b10;
                end
            end
            S_EXE_BR: begin
                alu_op_r  = 3'b001;
                ext_sel_r = 1'b1;
                pc_wre_r  = 1'b1;
                pc_src_r  = zero ? 2'b01 : 2'b00;
            end
            S_EXE_LS, S_MEM: begin
                alu_src_b_r = 1'b1;
                ext_sel_r   = 1'b1;
                if (state_q == S_MEM) begin
                    mrd_r    = is_lw;
                    mwr_r    = is_sw;
                    pc_wre_r = is_sw;
                end
            end
            S_WB_LD: begin
                mrd_r     = 1'b1;
                reg_wre_r = 1'b1;
                reg_dst_r = 2'b01;
                wr_src_r  = 1'b1;
                db_src_r  = 1'b1;
                pc_wre_r  = 1'b1;
            end
            default: ;
        endcase
    end

    // Gate with Reset so no enable can glitch out while the async reset is asserted
    assign PCWre     = Reset & pc_wre_r;
    assign PCSrc     = Reset ? pc_src_r : 2'b00;
    assign IRWre     = Reset & ir_wre_r;
    assign ExtSel    = Reset & ext_sel_r;
    assign ALUSrcA   = Reset & alu_src_a_r;
    assign ALUSrcB   = Reset & alu_src_b_r;
    assign ALUOp     = Reset ? alu_op_r : 3'b000;
    assign RegWre    = Reset & reg_wre_r;
    assign RegDst    = Reset ? reg_dst_r : 2'b00;
    assign WrRegDSrc = Reset & wr_src_r;
    assign DBDataSrc = Reset & db_src_r;
    assign mRD       = Reset & mrd_r;
    assign mWR       = Reset & mwr_r;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through its state sequence.
// Expectations for halt follow the MCTRL_HALT_EN build macro.
module tb_multicycle_ctrl;
    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero;
    logic       PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp, state;
    logic [16:0] ctl;

    int n_cmp = 0;
    int n_err = 0;
    int pc_pulses;

    multicycle_ctrl dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ExtSel(ExtSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWre(RegWre),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .mRD(mRD), .mWR(mWR), .state(state)
    );

    always #5 CLK = ~CLK;

    assign ctl = {PCWre, PCSrc, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
                  RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR};

    function automatic logic [16:0] mk(input logic pcwre, input logic [1:0] pcsrc,
                                       input logic irwre, input logic ext, input logic srca,
                                       input logic srcb, input logic [2:0] aluop,
                                       input logic regwre, input logic [1:0] regdst,
                                       input logic wrsrc, input logic dbsrc,
                                       input logic mrd, input logic mwr);
        return {pcwre, pcsrc, irwre, ext, srca, srcb, aluop, regwre, regdst, wrsrc, dbsrc, mrd, mwr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [16:0] w);
        chk({tag, "_state"}, {29'd0, state}, {29'd0, st});
        chk({tag, "_ctl"}, {15'd0, ctl}, {15'd0, w});
        if (PCWre === 1'b1) pc_pulses++;
    endtask

    task automatic do_alu(input string tag, input logic [5:0] op,
                          input logic [16:0] w_ex, input logic [16:0] w_wb);
        logic [16:0] w_if;
        w_if = mk(0, 2'b00, 1, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0);
        opcode = op;
        step(); expect_cyc({tag, "_id"}, 3'b001, 17'd0);
        step(); expect_cyc({tag, "_ex"}, 3'b110, w_ex);
        step(); expect_cyc({tag, "_wb"}, 3'b111, w_wb);
        step(); expect_cyc({tag, "_if"}, 3'b000, w_if);
    endtask

    task automatic do_short(input string tag, input logic [5:0] op, input logic [16:0] w_id);
        logic [16:0] w_if;
        w_if = mk(0, 2'b00, 1, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0);
        opcode = op;
        step(); expect_cyc({tag, "_id"}, 3'b001, w_id);
        step(); expect_cyc({tag, "_if"}, 3'b000, w_if);
    endtask

    initial begin
        logic [16:0] w_if, w_ls;
        w_if = mk(0, 2'b00, 1, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0);
        w_ls = mk(0, 2'b00, 0, 1, 0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 0);
        pc_pulses = 0;
        Reset  = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;

        #3;
        expect_cyc("rst", 3'b000, 17'd0);
        #9;
        Reset = 1'b1;
        #1;
        expect_cyc("if0", 3'b000, w_if);

        do_alu("add", 6'b000000, 17'd0,
               mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 1, 2'b10, 1, 0, 0, 0));
        do_alu("addi", 6'b000010,
               mk(0, 2'b00, 0, 1, 0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 0),
               mk(1, 2'b00, 0, 1, 0, 1, 3'b000, 1, 2'b01, 1, 0, 0, 0));
        do_alu("ori", 6'b010010,
               mk(0, 2'b00, 0, 0, 0, 1, 3'b010, 0, 2'b00, 0, 0, 0, 0),
               mk(1, 2'b00, 0, 0, 0, 1, 3'b010, 1, 2'b01, 1, 0, 0, 0));
        do_alu("sll", 6'b011000,
               mk(0, 2'b00, 0, 0, 1, 0, 3'b100, 0, 2'b00, 0, 0, 0, 0),
               mk(1, 2'b00, 0, 0, 1, 0, 3'b100, 1, 2'b10, 1, 0, 0, 0));
        do_alu("slt", 6'b100111,
               mk(0, 2'b00, 0, 0, 0, 0, 3'b101, 0, 2'b00, 0, 0, 0, 0),
               mk(1, 2'b00, 0, 0, 0, 0, 3'b101, 1, 2'b10, 1, 0, 0, 0));
        do_alu("sub", 6'b000001,
               mk(0, 2'b00, 0, 0, 0, 0, 3'b001, 0, 2'b00, 0, 0, 0, 0),
               mk(1, 2'b00, 0, 0, 0, 0, 3'b001, 1, 2'b10, 1, 0, 0, 0));
        do_alu("and", 6'b010001,
               mk(0, 2'b00, 0, 0, 0, 0, 3'b011, 0, 2'b00, 0, 0, 0, 0),
               mk(1, 2'b00, 0, 0, 0, 0, 3'b011, 1, 2'b10, 1, 0, 0, 0));

        // beq: zero must be ignored in sID and steer PCSrc only in sEXE_BR
        opcode = 6'b110100;
        zero   = 1'b0;
        step(); expect_cyc("beq_id", 3'b001, 17'd0);
        zero = 1'b1;
        #1;
        expect_cyc("beq_id_ztog", 3'b001, 17'd0);
        step(); expect_cyc("beq_ex_z1", 3'b101, mk(1, 2'b01, 0, 1, 0, 0, 3'b001, 0, 2'b00, 0, 0, 0, 0));
        zero = 1'b0;
        #1;
        expect_cyc("beq_ex_z0", 3'b101, mk(1, 2'b00, 0, 1, 0, 0, 3'b001, 0, 2'b00, 0, 0, 0, 0));
        step(); expect_cyc("beq_if", 3'b000, w_if);

        opcode    = 6'b110001;
        pc_pulses = 0;
        step(); expect_cyc("lw_id", 3'b001, 17'd0);
        step(); expect_cyc("lw_ex", 3'b010, w_ls);
        step(); expect_cyc("lw_mem", 3'b011, mk(0, 2'b00, 0, 1, 0, 1, 3'b000, 0, 2'b00, 0, 0, 1, 0));
        step(); expect_cyc("lw_wb", 3'b100, mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 1, 2'b01, 1, 1, 1, 0));
        step(); expect_cyc("lw_if", 3'b000, w_if);
        chk("lw_pcwre_pulses", pc_pulses, 1);

        do_short("jal", 6'b111010, mk(1, 2'b10, 0, 0, 0, 0, 3'b000, 1, 2'b00, 0, 0, 0, 0));
        do_short("j", 6'b111000, mk(1, 2'b10, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0));
        do_short("jr", 6'b111001, mk(1, 2'b11, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0));
        do_short("ill", 6'b000011, mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0));

`ifdef MCTRL_HALT_EN
        opcode = 6'b111111;
        step(); expect_cyc("halt_id", 3'b001, 17'd0);
        step();
        for (int i = 0; i < 20; i++) begin
            expect_cyc("halt_park", 3'b000, 17'd0);
            step();
        end
`else
        do_short("halt_nop", 6'b111111, mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0));
`endif

        Reset = 1'b0;
        #1;
        expect_cyc("rst2", 3'b000, 17'd0);
        step();
        Reset = 1'b1;
        #1;
        expect_cyc("rst2_if", 3'b000, w_if);

        // sw interrupted by reset while in sMEM
        opcode = 6'b110000;
        step(); expect_cyc("sw_id", 3'b001, 17'd0);
        step(); expect_cyc("sw_ex", 3'b010, w_ls);
        step(); expect_cyc("sw_mem", 3'b011, mk(1, 2'b00, 0, 1, 0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 1));
        #2;
        Reset = 1'b0;
        #1;
        expect_cyc("sw_rst", 3'b000, 17'd0);
        step();
        expect_cyc("sw_rst_hold", 3'b000, 17'd0);
        Reset = 1'b1;
        #1;
        expect_cyc("sw_rel_if", 3'b000, w_if);
        step(); expect_cyc("sw_rel_id", 3'b001, 17'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
